load_store_unit: RTL and testbench

Byte-addressed load/store front end that sits directly upstream of the 1024×32 word memory and is its only master. Accepts byte, halfword and word requests from the CPU datapath, and performs sub-word stores as a single-cycle read-modify-write against the memory's combinational read port. Returns sign- or zero-extended load data through a valid/ready response handshake.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_if.sv | 27 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 106 ++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size encodings, FSM states,
// latched request record and big-endian lane mapping.
package lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  // Big-endian: offset 0 is the most significant lane, so the last offset sits at bit 0.
  localparam logic [1:0] LSU_BYTE_LANE_LAST = 2'd3;
  localparam logic       LSU_HALF_LANE_LAST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    byte_shift = {LSU_BYTE_LANE_LAST - off, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(input logic off_hi);
    half_shift = {LSU_HALF_LANE_LAST ^ off_hi, 4'b0000};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_BYTE: is_misaligned = 1'b0;
      LSU_HALF: is_misaligned = off[0];
      default:  is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_BYTE: align_offset = off;
      LSU_HALF: align_offset = {off[1], 1'b0};
      default:  align_offset = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response handshake of the load/store unit.
// master = CPU datapath, slave = load_store_unit.
interface lsu_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane extract/extend for loads and lane merge for stores.
// Purely combinational, no backpressure.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign bsh = byte_shift(offset);
  assign hsh = half_shift(offset[1]);

  always_comb begin
    lane_b     = 8'(rdata >> bsh);
    lane_h     = 16'(rdata >> hsh);
    load_data  = rdata;
    store_data = wdata;
    case (size)
      LSU_BYTE: begin
        load_data  = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        store_data = (old_word & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata[7:0]} << bsh);
      end
      LSU_HALF: begin
        load_data  = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        store_data = (old_word & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata[15:0]} << hsh);
      end
      default: begin
        load_data  = rdata;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end; sub-word stores are a one-cycle read-modify-write. Optional LSU_ALIGN_CHECK_EN.
// Latency 3 cycles (2 when misaligned); one request in flight, req_ready only in IDLE, response held until resp_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_if.slave              bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state;
  lsu_state_e        state_nxt;
  lsu_req_t          req_q;
  logic [ADDR_W+1:0] addr_q;
  logic [ADDR_W+1:0] addr_in;
  logic              misaligned;
  logic              accept;
  logic              in_access;
  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  assign accept    = (state == ST_IDLE) && bus.req_valid;
  assign in_access = (state == ST_ACCESS);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign addr_in    = bus.req_addr;
`else
  // Without the check, low bits are silently rounded down to natural alignment.
  assign misaligned = 1'b0;
  assign addr_in    = {bus.req_addr[ADDR_W+1:2], align_offset(bus.req_size, bus.req_addr[1:0])};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = misaligned ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  lsu_lane_align u_lane_align (
    .rdata       (mem_rdata),
    .old_word    (mem_rdata),
    .wdata       (req_q.wdata),
    .offset      (addr_q[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // rst_n gates the strobe so a reset edge landing on ACCESS never commits a write.
  assign mem_we    = in_access & req_q.we & rst_n;
  assign mem_addr  = in_access ? addr_q[ADDR_W+1:2] : mem_addr_q;
  assign mem_wdata = (in_access && req_q.we) ? store_data : mem_wdata_q;

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q        <= '0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q.we          <= bus.req_we;
        req_q.size        <= bus.req_size;
        req_q.is_unsigned <= bus.req_unsigned;
        req_q.wdata       <= bus.req_wdata;
        addr_q            <= addr_in;
        resp_err_q        <= misaligned;
        resp_rdata_q      <= '0;
      end
      if (in_access) begin
        mem_addr_q   <= mem_addr;
        resp_rdata_q <= req_q.we ? 32'h0 : load_data;
        if (req_q.we) mem_wdata_q <= store_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural 1024x32 memory, reference memory model
// and a response scoreboard, plus cycle-level checks of handshake, write strobe and reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(10)) bus ();

  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_addr]  <= pl_data;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", bus.resp_rdata, mon_e.rdata);
        check("resp_err", {31'h0, bus.resp_err}, {31'h0, mon_e.err});
      end
    end
  end

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w;
    byte_of = t[31-8*k -: 8];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    wait_idle();
    pl_addr = w[9:0];
    pl_data = d;
    pl_en   = 1'b1;
    ref_mem[w] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Drives one request; returns 1 time unit after its accepting edge.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wd, input bit track);
    logic [11:0] a;
    logic        mis;
    int          w;
    int          off;
    logic [7:0]  b;
    logic [7:0]  bs [4];
    exp_t        e;
    wait_idle();
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    if (track) begin
      a   = addr;
      mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
`else
      if (sz == 2'd1) a[0] = 1'b0;
      else if (sz != 2'd0) a[1:0] = 2'b00;
`endif
      w   = int'(a[11:2]);
      off = int'(a[1:0]);
      e.err   = mis;
      e.rdata = 32'h0;
      if (!mis) begin
        for (int k = 0; k < 4; k++) bs[k] = byte_of(ref_mem[w], k);
        if (!we) begin
          case (sz)
            2'd0: begin
              b = bs[off];
              e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'd1: e.rdata = uns ? {16'h0, bs[off], bs[off+1]}
                                : {{16{bs[off][7]}}, bs[off], bs[off+1]};
            default: e.rdata = ref_mem[w];
          endcase
        end else begin
          case (sz)
            2'd0: bs[off] = wd[7:0];
            2'd1: begin
              bs[off]   = wd[15:8];
              bs[off+1] = wd[7:0];
            end
            default: begin
              bs[0] = wd[31:24]; bs[1] = wd[23:16]; bs[2] = wd[15:8]; bs[3] = wd[7:0];
            end
          endcase
          ref_mem[w] = {bs[0], bs[1], bs[2], bs[3]};
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = LSU_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    rst_n            = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);

    for (int i = 0; i < 16; i++) preload(i, $urandom);

    // Word store then word load, cycle by cycle
    do_req(1'b1, LSU_WORD, 1'b0, 12'h010, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("st_we_n1", {31'h0, mem_we}, 32'h1);
    check("st_addr_n1", {22'h0, mem_addr}, 32'd4);
    check("st_wdata_n1", mem_wdata, 32'hDEADBEEF);
    check("st_valid_n1", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    check("st_we_n2", {31'h0, mem_we}, 32'h0);
    check("st_valid_n2", {31'h0, bus.resp_valid}, 32'h1);
    check("st_mem4", mem[4], 32'hDEADBEEF);
    do_req(1'b0, LSU_WORD, 1'b0, 12'h010, 32'h0, 1'b1);
    @(negedge clk);
    check("ld_valid_n1", {31'h0, bus.resp_valid}, 32'h0);
    check("ld_we_n1", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check("ld_valid_n2", {31'h0, bus.resp_valid}, 32'h1);
    check("ld_rdata_n2", bus.resp_rdata, 32'hDEADBEEF);

    // Byte read-modify-write
    preload(4, 32'h11223344);
    do_req(1'b1, LSU_BYTE, 1'b0, 12'h012, 32'h000000AA, 1'b1);
    wait_idle();
    check("byte_store_mem4", mem[4], 32'h1122AA44);
    do_req(1'b1, LSU_HALF, 1'b0, 12'h010, 32'h0000BEEF, 1'b1);
    wait_idle();
    check("half_store_mem4", mem[4], 32'hBEEFAA44);

    // Sign/zero extension
    preload(4, 32'h80FF7F01);
    do_req(1'b0, LSU_BYTE, 1'b0, 12'h010, 32'h0, 1'b1);
    do_req(1'b0, LSU_BYTE, 1'b1, 12'h011, 32'h0, 1'b1);
    do_req(1'b0, LSU_HALF, 1'b0, 12'h012, 32'h0, 1'b1);
    do_req(1'b0, LSU_HALF, 1'b0, 12'h010, 32'h0, 1'b1);
    do_req(1'b0, LSU_BYTE, 1'b0, 12'h013, 32'h0, 1'b1);

    // Misaligned word load
    do_req(1'b0, LSU_WORD, 1'b0, 12'h013, 32'h0, 1'b1);
    @(negedge clk);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_valid_n1", {31'h0, bus.resp_valid}, 32'h1);
    check("mis_err_n1", {31'h0, bus.resp_err}, 32'h1);
    check("mis_we_n1", {31'h0, mem_we}, 32'h0);
`else
    check("mis_valid_n1", {31'h0, bus.resp_valid}, 32'h0);
    check("mis_addr_n1", {22'h0, mem_addr}, 32'd4);
`endif

    // Response backpressure
    preload(6, 32'hA5A50F0F);
    bus.resp_ready = 1'b0;
    do_req(1'b0, LSU_WORD, 1'b0, 12'h018, 32'h0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'h0, bus.resp_valid}, 32'h1);
      check("bp_rdata", bus.resp_rdata, 32'hA5A50F0F);
      check("bp_req_ready", {31'h0, bus.req_ready}, 32'h0);
    end
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_req_ready_rel", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    check("bp_idle_after", {31'h0, bus.req_ready}, 32'h1);

    // Reset during the ACCESS cycle of a store
    preload(5, 32'h12345678);
    do_req(1'b1, LSU_WORD, 1'b0, 12'h014, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_acc_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check("rst_acc_valid", {31'h0, bus.resp_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_acc_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_acc_mem5", mem[5], 32'h12345678);
    repeat (3) begin
      @(negedge clk);
      check("rst_acc_novalid", {31'h0, bus.resp_valid}, 32'h0);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 63)), $urandom, 1'b1);
    end
    wait_idle();
    for (int w = 0; w < 16; w++) check("final_mem", mem[w], ref_mem[w]);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
